// File: rtl/y_ctrl_seq_if.sv
// Control/datapath bundle between y_ctrl_seq (master) and the RV32 single-cycle datapath (slave).
interface y_ctrl_seq_if;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] imm;
  logic [31:0] jTarget;
  logic [31:0] PCin;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;

  modport master (
    input  ins, zero, imm, jTarget,
    output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg
  );

  modport slave (
    output ins, zero, imm, jTarget,
    input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg
  );
endinterface

// File: rtl/y_ctrl_seq.sv
// Five-cycle control sequencer for the RV32 single-cycle datapath.
// Optional retire trace ports (retire_valid/retire_pc) enabled by Y_CTRL_RETIRE_TRACE_EN.
module y_ctrl_seq #(
  parameter logic [31:0] RESET_PC = 32'h28,
  parameter int unsigned MAX_INS  = 43
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  y_ctrl_seq_if.master   dp,
  output logic [15:0]    ins_count,
  output logic           halted,
  output logic           illegal
`ifdef Y_CTRL_RETIRE_TRACE_EN
  ,
  output logic           retire_valid,
  output logic [31:0]    retire_pc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [31:0] MAX_W     = 32'(MAX_INS);
  localparam bit          HAS_LIMIT = (MAX_INS != 0);

  state_t      r_state, w_state_next;
  logic [31:0] r_pc;
  logic        r_alusrc, r_regwr, r_memrd, r_memwr, r_m2r, r_is_beq, r_is_jal;
  logic [2:0]  r_op;
  logic [15:0] r_count;
  logic        r_halted, r_illegal;

  logic        w_dec_legal, w_dec_alusrc, w_dec_regwr, w_dec_memrd, w_dec_memwr;
  logic        w_dec_m2r, w_dec_beq, w_dec_jal;
  logic [2:0]  w_dec_op;
  logic        w_last;
  logic [31:0] w_next_pc;
  logic        w_unused;

  assign w_unused = ^{dp.ins[31], dp.ins[29:15], dp.ins[11:7]};

  // Instruction decode; only meaningful while the FSM sits in DECODE.
  always_comb begin
    w_dec_legal  = 1'b0;
    w_dec_alusrc = 1'b0;
    w_dec_op     = 3'b010;
    w_dec_regwr  = 1'b0;
    w_dec_memrd  = 1'b0;
    w_dec_memwr  = 1'b0;
    w_dec_m2r    = 1'b0;
    w_dec_beq    = 1'b0;
    w_dec_jal    = 1'b0;
    case (dp.ins[6:0])
      7'h33: begin
        w_dec_regwr = 1'b1;
        case (dp.ins[14:12])
          3'b000: begin
            w_dec_legal = 1'b1;
            w_dec_op    = dp.ins[30] ? 3'b110 : 3'b010;
          end
          3'b110: begin
            w_dec_legal = 1'b1;
            w_dec_op    = 3'b001;
          end
          3'b111: begin
            w_dec_legal = 1'b1;
            w_dec_op    = 3'b000;
          end
          default: w_dec_legal = 1'b0;
        endcase
      end
      7'h13: begin
        w_dec_legal  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_regwr  = 1'b1;
      end
      7'h03: begin
        w_dec_legal  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_regwr  = 1'b1;
        w_dec_memrd  = 1'b1;
        w_dec_m2r    = 1'b1;
      end
      7'h23: begin
        w_dec_legal  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_memwr  = 1'b1;
      end
      7'h63: begin
        w_dec_legal = 1'b1;
        w_dec_op    = 3'b110;
        w_dec_beq   = 1'b1;
      end
      7'h6F: begin
        w_dec_legal  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_regwr  = 1'b1;
        w_dec_jal    = 1'b1;
      end
      default: w_dec_legal = 1'b0;
    endcase
  end

  // Halt test uses the unsaturated count so a limit above 16 bits simply never fires.
  assign w_last = HAS_LIMIT && ((32'(r_count) + 32'd1) == MAX_W);

  always_comb begin
    if (r_is_beq && dp.zero) begin
      w_next_pc = r_pc + (dp.imm << 1);
    end else if (r_is_jal) begin
      w_next_pc = r_pc + (dp.jTarget << 2);
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = w_dec_legal ? S_EXEC : S_HALT;
      S_EXEC:   w_state_next = S_MEM;
      S_MEM:    w_state_next = S_WB;
      S_WB: begin
        if (w_last)   w_state_next = S_HALT;
        else if (run) w_state_next = S_FETCH;
        else          w_state_next = S_IDLE;
      end
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_alusrc  <= 1'b0;
      r_op      <= 3'b010;
      r_regwr   <= 1'b0;
      r_memrd   <= 1'b0;
      r_memwr   <= 1'b0;
      r_m2r     <= 1'b0;
      r_is_beq  <= 1'b0;
      r_is_jal  <= 1'b0;
      r_count   <= 16'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        if (w_dec_legal) begin
          r_alusrc <= w_dec_alusrc;
          r_op     <= w_dec_op;
          r_regwr  <= w_dec_regwr;
          r_memrd  <= w_dec_memrd;
          r_memwr  <= w_dec_memwr;
          r_m2r    <= w_dec_m2r;
          r_is_beq <= w_dec_beq;
          r_is_jal <= w_dec_jal;
        end else begin
          r_illegal <= 1'b1;
        end
      end
      if (r_state == S_WB) begin
        r_pc    <= w_next_pc;
        r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
      end
      if (w_state_next == S_HALT) r_halted <= 1'b1;
    end
  end

  // Strobes decode straight from the state register so reset kills them immediately.
  always_comb begin
    dp.PCin     = r_pc;
    dp.RegWrite = 1'b0;
    dp.MemWrite = 1'b0;
    dp.MemRead  = 1'b0;
    dp.ALUSrc   = r_alusrc;
    dp.op       = r_op;
    dp.Mem2Reg  = r_m2r;
    case (r_state)
      S_DECODE: begin
        dp.ALUSrc  = w_dec_alusrc;
        dp.op      = w_dec_op;
        dp.Mem2Reg = w_dec_m2r;
        dp.MemRead = w_dec_legal && w_dec_memrd;
      end
      S_EXEC:  dp.MemRead = r_memrd;
      S_MEM: begin
        dp.MemRead  = r_memrd;
        dp.MemWrite = r_memwr;
      end
      S_WB: begin
        dp.MemRead  = r_memrd;
        dp.RegWrite = r_regwr;
      end
      default: ;
    endcase
  end

  assign ins_count = r_count;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

`ifdef Y_CTRL_RETIRE_TRACE_EN
  assign retire_valid = (r_state == S_WB);
  assign retire_pc    = (r_state == S_WB) ? r_pc : 32'd0;
`endif

endmodule

// File: doc/y_ctrl_seq.md
Name: y_ctrl_seq

Overview:
- Hardware control sequencer for the single-cycle RV32 datapath (yIF/yID/yEX/yDM/yWB).
- Drives the control side of the datapath that a bench drives by hand today: PC, RegWrite, ALUSrc, op, MemRead, MemWrite and Mem2Reg.
- Consumes ins, zero, imm and jTarget back from the datapath.
- Multi-cycle FSM: each instruction takes 5 cycles. Write strobes are confined to a single cycle each.

Parameters:
- RESET_PC, 32'h28: PC loaded on reset (program entry point).
- MAX_INS, 43: retired-instruction budget; HALT when reached; 0 = unlimited.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue request; sampled in IDLE and at end of WB.
- ins  in  32  instruction from yIF for the current PCin.
- zero  in  1  ALU zero flag from yEX.
- imm  in  32  sign-extended immediate from yID.
- jTarget  in  32  JAL offset from yID, in words.
- PCin  out  32  PC presented to yIF.
- RegWrite  out  1  register-file write strobe.
- ALUSrc  out  1  0 = rd2, 1 = imm.
- op  out  3  ALU operation.
- MemRead  out  1  data-memory read enable.
- MemWrite  out  1  data-memory write strobe.
- Mem2Reg  out  1  writeback select: 1 = memOut, 0 = z.
- ins_count  out  16  number of retired instructions.
- halted  out  1  sticky; set in HALT.
- illegal  out  1  sticky; set when an unknown opcode is decoded.

Behaviour:
- Reset (async, immediate on rst_n low):
  - PCin = RESET_PC, op = 3'b010, all other control outputs 0.
  - ins_count = 0, halted = 0, illegal = 0, state = IDLE.
  - Reset mid-instruction aborts it; no strobe survives the reset assertion.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Transitions:
  - IDLE -> FETCH when run = 1.
  - FETCH -> DECODE -> EXEC -> MEM -> WB, unconditionally.
  - WB -> HALT if ins_count+1 == MAX_INS and MAX_INS != 0.
  - Otherwise WB -> FETCH if run = 1, WB -> IDLE if run = 0.
  - DECODE -> HALT with illegal = 1 on an unknown opcode. PC is not advanced and nothing is retired.
  - HALT is terminal until reset.
- FETCH: PCin stable; ins is valid by the end of the cycle.
- DECODE: registers the control word from ins[6:0] and ins[14:12]. The word is held constant through EXEC, MEM and WB:
  - 0x33 R-type: ALUSrc = 0, reg write.
    - funct3 000 with ins[30] = 0 -> op 010 (add).
    - funct3 000 with ins[30] = 1 -> op 110 (sub).
    - funct3 110 -> op 001 (or).
    - funct3 111 -> op 000 (and).
    - Any other funct3 -> illegal.
  - 0x13 ADDI: ALUSrc = 1, op 010, reg write.
  - 0x03 LW: ALUSrc = 1, op 010, MemRead = 1, Mem2Reg = 1, reg write.
  - 0x23 SW: ALUSrc = 1, op 010, mem write.
  - 0x63 BEQ: ALUSrc = 0, op 110, no writes.
  - 0x6F JAL: ALUSrc = 1, op 010, reg write.
- MemRead is held level from DECODE through WB for LW only.
- MemWrite = 1 only during the MEM cycle of SW.
- RegWrite = 1 only during the WB cycle of R-type, ADDI, LW and JAL.
- Next-PC rule, 32-bit wrapping adds, PCin updated on the WB -> next transition:
  - BEQ with zero = 1 (sampled in WB): PCin + (imm << 1).
  - JAL: PCin + (jTarget << 2).
  - Otherwise: PCin + 4.
- ins_count increments by 1 at every WB exit and saturates at 16'hFFFF.
- run dropping mid-instruction never truncates that instruction.
- Entering IDLE from WB keeps the updated PCin; a later run = 1 resumes from that PC.
- In IDLE and HALT: RegWrite = MemWrite = MemRead = 0; PCin frozen.

Optional Feature:
- Macro: Y_CTRL_RETIRE_TRACE_EN.
- Defined:
  - Adds output ports retire_valid (1 bit) and retire_pc (32 bits).
  - retire_valid pulses high for exactly the WB cycle of every retired instruction.
  - retire_pc holds that instruction's PC (pre-update) during the pulse; both reset to 0.
  - An illegal instruction produces no pulse.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, run = 1, ins = ADDI at 0x28 -> RegWrite high only in cycle 5, ALUSrc = 1, op = 010; PCin = 0x2C after WB; ins_count = 1.
- R-type funct3 = 110 -> op = 001, ALUSrc = 0. funct3 = 000 with ins[30] = 1 -> op = 110.
- BEQ at PC 0x30, imm = 8, zero = 1 -> next PCin = 0x40. Same with zero = 0 -> 0x34. RegWrite and MemWrite stay 0 throughout.
- JAL at 0x40, jTarget = 3 -> next PCin = 0x4C, RegWrite pulses in WB.
- SW then LW:
  - SW -> MemWrite high only in MEM.
  - LW -> MemRead high DECODE..WB, Mem2Reg = 1.
  - rst_n low during SW's MEM -> MemWrite falls immediately, PCin = 0x28, IDLE.
- MAX_INS = 2, ADDI stream -> halted = 1 after 10 cycles, ins_count = 2, no further strobes. Separately, opcode 0x7F -> illegal = 1, halted = 1, PCin unchanged.
